// File: rtl/syscall_unit_if.sv
// Handshake bundle between the CPU datapath (master) and the syscall responder (slave).
interface syscall_if #(
  parameter int COUNT_W = 16
);
  logic               in_syscall;
  logic [31:0]        in_rdata;
  logic               in_disp_ready;
  logic               in_go;
  logic [4:0]         out_rsel;
  logic               out_rsel_en;
  logic               out_stall;
  logic               out_halt;
  logic               out_disp_valid;
  logic [31:0]        out_disp_data;
  logic               out_done;
  logic [COUNT_W-1:0] out_count;

  modport master (
    output in_syscall, in_rdata, in_disp_ready, in_go,
    input  out_rsel, out_rsel_en, out_stall, out_halt,
    input  out_disp_valid, out_disp_data, out_done, out_count
  );

  modport slave (
    input  in_syscall, in_rdata, in_disp_ready, in_go,
    output out_rsel, out_rsel_en, out_stall, out_halt,
    output out_disp_valid, out_disp_data, out_done, out_count
  );
endinterface

// File: rtl/syscall_unit.sv
// SYSCALL responder: stalls the PC, reads $v0/$a0 via a borrowed regfile port,
// then prints $a0 or halts until GO, and counts retired syscalls.
module syscall_unit #(
  parameter int          COUNT_W    = 16,
  parameter logic [31:0] PRINT_CODE = 32'd1,
  parameter logic [31:0] EXIT_CODE  = 32'd10,
  parameter logic [4:0]  V0_IDX     = 5'd2,
  parameter logic [4:0]  A0_IDX     = 5'd4
) (
  input logic      in_clk,
  input logic      in_rst_n,
  syscall_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, RD_V0, RD_A0, DISPATCH, OUT, HALT, RELEASE
  } state_t;

  state_t             state;
  logic [31:0]        v0_q;
  logic [31:0]        a0_q;
  logic [COUNT_W-1:0] count_q;

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      state   <= IDLE;
      v0_q    <= '0;
      a0_q    <= '0;
      count_q <= '0;
    end else begin
      case (state)
        IDLE:     if (bus.in_syscall) state <= RD_V0;
        RD_V0: begin
          v0_q  <= bus.in_rdata;
          state <= RD_A0;
        end
        RD_A0: begin
          a0_q  <= bus.in_rdata;
          state <= DISPATCH;
        end
        DISPATCH: begin
          if      (v0_q == PRINT_CODE) state <= OUT;
          else if (v0_q == EXIT_CODE)  state <= HALT;
          else                         state <= RELEASE;
        end
        OUT:      if (bus.in_disp_ready) state <= RELEASE;
        HALT:     if (bus.in_go)         state <= RELEASE;
        RELEASE: begin
          // Saturate rather than wrap so a long run never reads as "few calls".
          if (count_q != {COUNT_W{1'b1}}) count_q <= count_q + 1'b1;
          state <= IDLE;
        end
        default:  state <= IDLE;
      endcase
    end
  end

  // Outputs decode the registered state so reset drops them immediately;
  // only the IDLE stall is a same-cycle reflection of the decoder flag.
  always_comb begin
    bus.out_rsel       = '0;
    bus.out_rsel_en    = 1'b0;
    bus.out_stall      = 1'b0;
    bus.out_halt       = 1'b0;
    bus.out_disp_valid = 1'b0;
    bus.out_disp_data  = '0;
    bus.out_done       = 1'b0;
    case (state)
      IDLE:     bus.out_stall = bus.in_syscall;
      RD_V0: begin
        bus.out_rsel    = V0_IDX;
        bus.out_rsel_en = 1'b1;
        bus.out_stall   = 1'b1;
      end
      RD_A0: begin
        bus.out_rsel    = A0_IDX;
        bus.out_rsel_en = 1'b1;
        bus.out_stall   = 1'b1;
      end
      DISPATCH: bus.out_stall = 1'b1;
      OUT: begin
        bus.out_stall      = 1'b1;
        bus.out_disp_valid = 1'b1;
        bus.out_disp_data  = a0_q;
      end
      HALT: begin
        bus.out_stall = 1'b1;
        bus.out_halt  = 1'b1;
      end
      RELEASE:  bus.out_done = 1'b1;
      default:  ;
    endcase
  end

  assign bus.out_count = count_q;

endmodule

// File: tb/tb_syscall_unit.sv
// Directed bench for syscall_unit: table of syscalls checked cycle by cycle,
// plus reset-during-print and counter saturation sequences.
module tb_syscall_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  syscall_if #(.COUNT_W(16)) b1 ();
  syscall_if #(.COUNT_W(2))  b2 ();

  syscall_unit #(.COUNT_W(16)) dut  (.in_clk(clk), .in_rst_n(rst_n), .bus(b1.slave));
  syscall_unit #(.COUNT_W(2))  dut2 (.in_clk(clk), .in_rst_n(rst_n), .bus(b2.slave));

  // Regfile model: combinational read of $v0/$a0 by index.
  logic [31:0] v0, a0;
  assign b1.in_rdata = (b1.out_rsel == 5'd2) ? v0 : (b1.out_rsel == 5'd4) ? a0 : 32'h0;
  assign b2.in_rdata = (b2.out_rsel == 5'd2) ? v0 : (b2.out_rsel == 5'd4) ? a0 : 32'h0;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // {stall, rsel_en, rsel, halt, disp_valid, disp_data, done}
  function automatic logic [41:0] obs1();
    return {b1.out_stall, b1.out_rsel_en, b1.out_rsel, b1.out_halt,
            b1.out_disp_valid, b1.out_disp_data, b1.out_done};
  endfunction

  // kind: 0 print, 1 exit, 2 other. dcyc: cycle of the done pulse.
  typedef struct {
    logic [31:0] v0;
    logic [31:0] a0;
    int          kind;
    int          rdly;
    int          gdly;
    int          dcyc;
    bit          hold;
    logic [15:0] cnt;
  } vec_t;

  vec_t tbl [6];

  initial begin
    logic [1:0] exp_sat [5];
    tbl[0] = '{32'd1,          32'h0000_1234, 0, 0, 0,  5,  1'b0, 16'd1};
    tbl[1] = '{32'd1,          32'hDEAD_BEEF, 0, 3, 0,  8,  1'b0, 16'd2};
    tbl[2] = '{32'd10,         32'h0000_0077, 1, 0, 20, 25, 1'b1, 16'd3};
    tbl[3] = '{32'd5,          32'h0000_0099, 2, 0, 0,  4,  1'b0, 16'd4};
    tbl[4] = '{32'h8000_0001,  32'h0000_0001, 2, 0, 0,  4,  1'b0, 16'd5};
    tbl[5] = '{32'h0000_010A,  32'h0000_0002, 2, 0, 0,  4,  1'b1, 16'd6};
    exp_sat = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

    v0 = '0; a0 = '0;
    b1.in_syscall = 1'b0; b1.in_disp_ready = 1'b0; b1.in_go = 1'b0;
    b2.in_syscall = 1'b0; b2.in_disp_ready = 1'b0; b2.in_go = 1'b0;

    #12;
    chk("reset_outputs", {22'h0, obs1()}, 64'h0);
    chk("reset_count", {48'h0, b1.out_count}, 64'h0);
    @(negedge clk) rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      logic        e_stall, e_en, e_halt, e_val, e_done;
      logic [4:0]  e_rsel;
      logic [31:0] e_data;
      int          d;
      d = tbl[i].dcyc;
      v0 = tbl[i].v0;
      a0 = tbl[i].a0;
      for (int c = 0; c <= d + 1; c++) begin
        @(posedge clk); #1;
        b1.in_syscall    = (c == 0) || (tbl[i].hold && c <= d);
        b1.in_disp_ready = !(c >= 4 && c < 4 + tbl[i].rdly);
        b1.in_go         = (tbl[i].kind == 1) && (c == 4 + tbl[i].gdly);
        @(negedge clk);
        e_stall = (c < d);
        e_en    = (c == 1) || (c == 2);
        e_rsel  = (c == 1) ? 5'd2 : (c == 2) ? 5'd4 : 5'd0;
        e_halt  = (tbl[i].kind == 1) && c >= 4 && c < d;
        e_val   = (tbl[i].kind == 0) && c >= 4 && c < d;
        e_data  = e_val ? tbl[i].a0 : 32'h0;
        e_done  = (c == d);
        chk($sformatf("vec%0d_c%0d", i, c), {22'h0, obs1()},
            {22'h0, e_stall, e_en, e_rsel, e_halt, e_val, e_data, e_done});
      end
      chk($sformatf("vec%0d_count", i), {48'h0, b1.out_count}, {48'h0, tbl[i].cnt});
    end

    // Reset while the print is waiting on a stalled display.
    v0 = 32'd1; a0 = 32'h0000_55AA;
    for (int c = 0; c <= 5; c++) begin
      @(posedge clk); #1;
      b1.in_syscall    = (c == 0);
      b1.in_disp_ready = 1'b0;
      b1.in_go         = 1'b0;
    end
    @(negedge clk);
    chk("rst_pre_valid", {63'h0, b1.out_disp_valid}, 64'h1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mid_outputs", {22'h0, obs1()}, 64'h0);
    chk("rst_mid_count", {48'h0, b1.out_count}, 64'h0);
    @(negedge clk) rst_n = 1'b1;
    b1.in_disp_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_after_idle", {22'h0, obs1()}, 64'h0);
    chk("rst_after_count", {48'h0, b1.out_count}, 64'h0);

    // Saturating 2-bit counter with syscall held high (back-to-back calls).
    v0 = 32'd7; a0 = 32'h0;
    @(posedge clk); #1;
    b2.in_syscall = 1'b1;
    for (int k = 0; k < 5; k++) begin
      int n;
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!b2.out_done && n < 20);
      chk($sformatf("sat_done%0d", k), {63'h0, b2.out_done}, 64'h1);
      @(negedge clk);
      chk($sformatf("sat_count%0d", k), {62'h0, b2.out_count}, {62'h0, exp_sat[k]});
    end
    b2.in_syscall = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
